div_req_sched: RTL and testbench

Round-robin scheduler that shares one serial divisible-by-N checker between `NUM_REQ` requesters. It accepts a parallel word from the winning requester and clears the checker. It then shifts the word into the checker MSB-first, one bit per cycle, captures the checker's verdict after the last bit, and returns a one-cycle response to the original requester. It sits between the requester ports and the checker's `bitstream`/`bitstream_vld`/`divisible`/`result_vld` pins.

---
 rtl/div_req_sched.sv | 198 +++++++++++++++++++
 tb/tb_div_req_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_req_sched.sv
// div_req_sched: round-robin front end for one shared serial divisibility checker.
// A winning requester's word is latched, the checker is cleared for one cycle,
// the word is shifted in MSB-first, and the checker's verdict after the last
// result is returned as a one-cycle strobe to the requester that was served.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   req_vld/req_data      per-requester request valid and word (i at [i*WORD_W +: WORD_W])
//   req_rdy               combinational one-hot accept, only in IDLE
//   rsp_vld/rsp_divisible one-cycle one-hot response strobe and verdict
//   busy                  high whenever not IDLE
//   chk_rst_n             active-low clear to the checker
//   chk_bitstream(_vld)   serial bit and its valid to the checker
//   chk_divisible         checker verdict for the prefix so far
//   chk_result_vld        checker result strobe, one per consumed bit
module div_req_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WORD_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_vld,
    input  logic [NUM_REQ*WORD_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_rdy,
    output logic [NUM_REQ-1:0]          rsp_vld,
    output logic                        rsp_divisible,
    output logic                        busy,
    output logic                        chk_rst_n,
    output logic                        chk_bitstream,
    output logic                        chk_bitstream_vld,
    input  logic                        chk_divisible,
    input  logic                        chk_result_vld
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int unsigned CW = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                verdict_q, verdict_d;

    logic [NUM_REQ-1:0]  rsp_vld_q, rsp_vld_d;
    logic                rsp_divisible_q, rsp_divisible_d;
    logic                busy_q, busy_d;
    logic                chk_rst_n_q, chk_rst_n_d;
    logic                chk_bitstream_q, chk_bitstream_d;
    logic                chk_bitstream_vld_q, chk_bitstream_vld_d;

    logic                win_found;
    logic [GW-1:0]       win_idx;
    int unsigned         cand;

    // Round-robin search starting just after the last grant, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(last_grant_q) + i + 32'd1) % NUM_REQ;
            if (!win_found && req_vld[GW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = GW'(cand);
            end
        end
    end

    // Accept only in IDLE and never while reset is asserted.
    always_comb begin
        req_rdy = '0;
        if (state_q == S_IDLE && !rst && win_found) begin
            req_rdy = NUM_REQ'(1) << win_idx;
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        verdict_d    = verdict_q;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d      = S_CLEAR;
                    word_d       = req_data[32'(win_idx) * WORD_W +: WORD_W];
                    grant_d      = win_idx;
                    last_grant_d = win_idx;
                end
            end
            S_CLEAR: begin
                state_d = S_SHIFT;
                idx_d   = IW'(WORD_W - 1);
                cnt_d   = '0;
            end
            S_SHIFT: begin
                if (idx_q == '0) begin
                    state_d = S_WAIT;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_WAIT: begin
                state_d = S_WAIT;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results are counted only while a word is in flight; the last one carries the verdict.
        if ((state_q == S_SHIFT || state_q == S_WAIT) && chk_result_vld) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(WORD_W)) begin
                verdict_d = chk_divisible;
                state_d   = S_RESP;
            end
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        rsp_vld_d           = '0;
        rsp_divisible_d     = 1'b0;
        busy_d              = (state_d != S_IDLE);
        chk_rst_n_d         = (state_d != S_CLEAR);
        chk_bitstream_d     = 1'b0;
        chk_bitstream_vld_d = 1'b0;
        if (state_d == S_SHIFT) begin
            chk_bitstream_vld_d = 1'b1;
            chk_bitstream_d     = word_d[idx_d];
        end
        if (state_d == S_RESP) begin
            rsp_vld_d       = NUM_REQ'(1) << grant_d;
            rsp_divisible_d = verdict_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= S_IDLE;
            word_q              <= '0;
            grant_q             <= '0;
            last_grant_q        <= GW'(NUM_REQ - 1);
            idx_q               <= '0;
            cnt_q               <= '0;
            verdict_q           <= 1'b0;
            rsp_vld_q           <= '0;
            rsp_divisible_q     <= 1'b0;
            busy_q              <= 1'b0;
            chk_rst_n_q         <= 1'b0;
            chk_bitstream_q     <= 1'b0;
            chk_bitstream_vld_q <= 1'b0;
        end else begin
            state_q             <= state_d;
            word_q              <= word_d;
            grant_q             <= grant_d;
            last_grant_q        <= last_grant_d;
            idx_q               <= idx_d;
            cnt_q               <= cnt_d;
            verdict_q           <= verdict_d;
            rsp_vld_q           <= rsp_vld_d;
            rsp_divisible_q     <= rsp_divisible_d;
            busy_q              <= busy_d;
            chk_rst_n_q         <= chk_rst_n_d;
            chk_bitstream_q     <= chk_bitstream_d;
            chk_bitstream_vld_q <= chk_bitstream_vld_d;
        end
    end

    assign rsp_vld           = rsp_vld_q;
    assign rsp_divisible     = rsp_divisible_q;
    assign busy              = busy_q;
    assign chk_rst_n         = chk_rst_n_q;
    assign chk_bitstream     = chk_bitstream_q;
    assign chk_bitstream_vld = chk_bitstream_vld_q;

endmodule

// File: tb/tb_div_req_sched.sv
// Bench for div_req_sched: a 4x8 instance and a 1x1 instance, each driving a
// divisible-by-3 serial checker stub with adjustable result latency.
module tb_div_req_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  req_vld;
    logic [31:0] req_data;
    logic [3:0]  req_rdy;
    logic [3:0]  rsp_vld;
    logic        rsp_divisible, busy, chk_rst_n, chk_bitstream, chk_bitstream_vld;
    logic        chk_divisible, chk_result_vld;

    logic [0:0]  r1_req_vld, r1_req_data, r1_req_rdy, r1_rsp_vld;
    logic        r1_rsp_divisible, r1_busy, r1_chk_rst_n, r1_chk_bitstream, r1_chk_bitstream_vld;
    logic        r1_chk_divisible, r1_chk_result_vld;

    div_req_sched #(.NUM_REQ(4), .WORD_W(8)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_divisible(rsp_divisible), .busy(busy),
        .chk_rst_n(chk_rst_n), .chk_bitstream(chk_bitstream), .chk_bitstream_vld(chk_bitstream_vld),
        .chk_divisible(chk_divisible), .chk_result_vld(chk_result_vld)
    );

    div_req_sched #(.NUM_REQ(1), .WORD_W(1)) dut1 (
        .clk(clk), .rst(rst), .req_vld(r1_req_vld), .req_data(r1_req_data), .req_rdy(r1_req_rdy),
        .rsp_vld(r1_rsp_vld), .rsp_divisible(r1_rsp_divisible), .busy(r1_busy),
        .chk_rst_n(r1_chk_rst_n), .chk_bitstream(r1_chk_bitstream), .chk_bitstream_vld(r1_chk_bitstream_vld),
        .chk_divisible(r1_chk_divisible), .chk_result_vld(r1_chk_result_vld)
    );

    // Divisible-by-3 checker stub with result latency lat (1..4) plus a spurious-strobe injector.
    int         lat = 1;
    logic       spur = 1'b0;
    logic [1:0] rem;
    logic [3:0] pv, pd;
    int         stub_nr;
    always @(posedge clk) begin
        if (!chk_rst_n) begin
            rem <= '0; pv <= '0; pd <= '0;
        end else begin
            stub_nr = chk_bitstream_vld ? (2 * int'(rem) + int'(chk_bitstream)) % 3 : int'(rem);
            rem <= 2'(stub_nr);
            pv  <= {pv[2:0], chk_bitstream_vld};
            pd  <= {pd[2:0], stub_nr == 0};
        end
    end
    assign chk_result_vld = pv[lat-1] | spur;
    assign chk_divisible  = pd[lat-1];

    logic [1:0] r1_rem;
    logic       r1_pv, r1_pd;
    int         r1_nr;
    always @(posedge clk) begin
        if (!r1_chk_rst_n) begin
            r1_rem <= '0; r1_pv <= 1'b0; r1_pd <= 1'b0;
        end else begin
            r1_nr  = r1_chk_bitstream_vld ? (2 * int'(r1_rem) + int'(r1_chk_bitstream)) % 3 : int'(r1_rem);
            r1_rem <= 2'(r1_nr);
            r1_pv  <= r1_chk_bitstream_vld;
            r1_pd  <= (r1_nr == 0);
        end
    end
    assign r1_chk_result_vld = r1_pv;
    assign r1_chk_divisible  = r1_pd;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller has raised the request in the current cycle (T0); runs the full service timeline.
    task automatic serve(input int r, input logic [7:0] d, input logic exp_div, input string tag);
        logic [3:0] oh;
        oh = 4'(1 << r);
        #1;
        check({tag, " req_rdy T0"}, 32'(req_rdy), 32'(oh));
        step();
        req_vld[r] = 1'b0;
        check({tag, " chk_rst_n T1"}, 32'(chk_rst_n), 32'd0);
        check({tag, " busy T1"}, 32'(busy), 32'd1);
        for (int k = 0; k < 8; k++) begin
            step();
            check({tag, " bit_vld"}, 32'(chk_bitstream_vld), 32'd1);
            check({tag, " bit"}, 32'(chk_bitstream), 32'(d[7-k]));
        end
        for (int k = 0; k < lat; k++) step();
        check({tag, " rsp_vld early"}, 32'(rsp_vld), 32'd0);
        check({tag, " bit_vld after"}, 32'(chk_bitstream_vld), 32'd0);
        step();
        check({tag, " rsp_vld"}, 32'(rsp_vld), 32'(oh));
        check({tag, " rsp_divisible"}, 32'(rsp_divisible), 32'(exp_div));
        step();
        check({tag, " busy end"}, 32'(busy), 32'd0);
        check({tag, " rsp_vld end"}, 32'(rsp_vld), 32'd0);
    endtask

    typedef struct {
        int         r;
        logic [7:0] d;
        logic       div;
    } vec_t;

    vec_t vecs[7];
    logic seen;

    initial begin
        vecs[0] = '{0, 8'd9,   1'b1};
        vecs[1] = '{2, 8'd10,  1'b0};
        vecs[2] = '{1, 8'd0,   1'b1};
        vecs[3] = '{3, 8'd255, 1'b1};
        vecs[4] = '{0, 8'd254, 1'b0};
        vecs[5] = '{2, 8'd3,   1'b1};
        vecs[6] = '{1, 8'd7,   1'b0};

        rst = 1'b1; req_vld = 4'hF; req_data = '0;
        r1_req_vld = '0; r1_req_data = '0;
        step(); step();
        check("rdy in reset", 32'(req_rdy), 32'd0);
        check("rst rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst rsp_div", 32'(rsp_divisible), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst chk_rst_n", 32'(chk_rst_n), 32'd0);
        check("rst bit", 32'(chk_bitstream), 32'd0);
        check("rst bit_vld", 32'(chk_bitstream_vld), 32'd0);
        req_vld = '0;
        rst = 1'b0;
        #1;
        check("chk_rst_n first cycle", 32'(chk_rst_n), 32'd0);
        step();
        check("chk_rst_n idle", 32'(chk_rst_n), 32'd1);

        // Single-requester vectors.
        for (int i = 0; i < 7; i++) begin
            req_data[vecs[i].r*8 +: 8] = vecs[i].d;
            req_vld[vecs[i].r] = 1'b1;
            serve(vecs[i].r, vecs[i].d, vecs[i].div, $sformatf("vec%0d", i));
        end

        // All four requesting from reset: 0,1,2,3 back to back.
        rst = 1'b1; step(); rst = 1'b0;
        req_data = {8'd5, 8'd3, 8'd10, 8'd9};
        req_vld  = 4'hF;
        serve(0, 8'd9,  1'b1, "rr0");
        serve(1, 8'd10, 1'b0, "rr1");
        serve(2, 8'd3,  1'b1, "rr2");
        serve(3, 8'd5,  1'b0, "rr3");
        // Grant 2 alone, then 1 and 3 together: 3 wins before 1.
        req_vld[2] = 1'b1;
        serve(2, 8'd3, 1'b1, "solo2");
        req_vld = 4'b1010;
        serve(3, 8'd5,  1'b0, "after2 first");
        serve(1, 8'd10, 1'b0, "after2 second");

        // Reset in the middle of SHIFT.
        req_data[15:8] = 8'd9;
        req_vld[1] = 1'b1;
        #1;
        check("rstmid rdy T0", 32'(req_rdy), 32'b0010);
        step();
        req_vld[1] = 1'b0;
        repeat (4) step();
        check("rstmid shifting T5", 32'(chk_bitstream_vld), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid chk_rst_n", 32'(chk_rst_n), 32'd0);
        check("rstmid bit_vld", 32'(chk_bitstream_vld), 32'd0);
        check("rstmid bit", 32'(chk_bitstream), 32'd0);
        check("rstmid busy", 32'(busy), 32'd0);
        check("rstmid rsp_vld", 32'(rsp_vld), 32'd0);
        check("rstmid rsp_div", 32'(rsp_divisible), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            seen = seen | (|rsp_vld);
        end
        check("rstmid no response", 32'(seen), 32'd0);
        // History was reset, so requester 1 beats requester 2.
        req_data[23:16] = 8'd10;
        req_vld = 4'b0110;
        serve(1, 8'd9,  1'b1, "reissue1");
        serve(2, 8'd10, 1'b0, "reissue2");

        // Checker latency 3 with spurious strobes while idle.
        lat  = 3;
        spur = 1'b1;
        step(); step(); step();
        spur = 1'b0;
        req_data[7:0] = 8'd9;
        req_vld[0] = 1'b1;
        serve(0, 8'd9, 1'b1, "lat3");
        req_data[31:24] = 8'd254;
        req_vld[3] = 1'b1;
        serve(3, 8'd254, 1'b0, "lat3 b");
        lat = 1;

        // One requester, one-bit words.
        for (int v = 0; v < 2; v++) begin
            r1_req_data = 1'(v);
            r1_req_vld  = 1'b1;
            #1;
            check("w1 rdy", 32'(r1_req_rdy), 32'd1);
            step();
            r1_req_vld = 1'b0;
            check("w1 chk_rst_n T1", 32'(r1_chk_rst_n), 32'd0);
            check("w1 busy T1", 32'(r1_busy), 32'd1);
            step();
            check("w1 bit_vld T2", 32'(r1_chk_bitstream_vld), 32'd1);
            check("w1 bit T2", 32'(r1_chk_bitstream), 32'(v));
            step();
            check("w1 bit_vld T3", 32'(r1_chk_bitstream_vld), 32'd0);
            check("w1 rsp early T3", 32'(r1_rsp_vld), 32'd0);
            step();
            check("w1 rsp_vld T4", 32'(r1_rsp_vld), 32'd1);
            check("w1 rsp_div T4", 32'(r1_rsp_divisible), 32'(v == 0));
            check("w1 busy T4", 32'(r1_busy), 32'd1);
            step();
            check("w1 busy T5", 32'(r1_busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
